recepcion: RTL and testbench
============================

Name: recepcion

Overview:
- UART receiver for the Bluetooth serial link, 8N1, LSB first.
- Consumes the serial line produced by the transmision stage, or by the external Bluetooth module.
- Recovers each byte and presents it on a parallel bus with a one-cycle done strobe.
- Flags framing errors and rejects start-bit glitches.

Parameters:
- CLKS_PER_BIT, 5208, clk_in cycles per bit period (50 MHz / 9600 baud); must be >= 8.
- CNT_W, 13, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  asynchronous serial line; idles high.
- dout  output  8  last correctly received byte.
- busy  output  1  high while a frame is being received (START, DATA or STOP state).
- done  output  1  one-cycle pulse: a valid byte has just been loaded into dout.
- ferr  output  1  one-cycle pulse: the stop bit was sampled low.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; counters cleared.
  - dout=8'h00, busy=0, done=0, ferr=0.
  - Both synchronizer flops set to 1.
  - Reset asserted mid-frame aborts the frame; no done or ferr pulse is produced.
- Input synchronizer: rx passes through a 2-flop synchronizer to give rx_s. The FSM uses only rx_s.
- Edge reference: T = the first rising edge at which rx_s == 0 while in IDLE.
- IDLE:
  - busy=0.
  - On rx_s==0: go to START and clear the counter.
- START:
  - Count to floor(CLKS_PER_BIT/2)-1, then sample rx_s.
  - Sample 0: clear the counter and bit index, go to DATA.
  - Sample 1: glitch; return to IDLE with no pulse.
- DATA:
  - Count CLKS_PER_BIT cycles, then sample rx_s into shift register bit[idx], idx 0..7, LSB first.
  - After idx 7 is sampled, go to STOP.
- STOP:
  - Count CLKS_PER_BIT cycles, then sample rx_s.
  - Sample 1: dout <= shift register, done=1 for exactly one cycle, go to IDLE.
  - Sample 0: dout is unchanged, ferr=1 for one cycle, go to WAIT_HI.
- WAIT_HI (line break or bad frame):
  - busy=0.
  - Stay until rx_s==1, then go to IDLE.
  - This prevents a held-low line from retriggering receptions.
- Registered outputs:
  - done/ferr are registered and asserted in the cycle after the stop sample, i.e. at T + floor(C/2) + 9*C + 1, where C = CLKS_PER_BIT.
  - busy is asserted from the cycle after T until the cycle done or ferr asserts; it is low in that pulse cycle.
- dout holding:
  - dout holds its value until the next valid frame.
  - There is no consumer handshake; a byte not read before the next done is overwritten.
- Back-to-back frames: a start edge seen in IDLE on the cycle after done begins a new frame with no lost bits (zero idle bits tolerated beyond the stop bit).
- done and ferr are never high in the same cycle.
- Counter wrap:
  - The counter resets on every state transition and at each bit sample.
  - It never free-runs past CLKS_PER_BIT-1.

Test Plan (CLKS_PER_BIT=16, bench drives rx with 16-cycle bits):
- Reset with reset=0 held 5 cycles, rx=1 -> dout=8'h00, busy=0, done=0, ferr=0. Release reset, then idle 100 cycles -> no pulses.
- Send 8'h33 (start, 1,1,0,0,1,1,0,0, stop) -> done pulses once at T+153, dout=8'h33, busy high T+1..T+152.
- Send 8'hA5 then 8'h3C back-to-back with no idle gap -> two done pulses 160 cycles apart. dout=8'hA5 after the first pulse, 8'h3C after the second.
- Framing error: send 8'h55 with stop bit=0, then hold rx low 40 cycles -> ferr pulse at T+153, no done, dout unchanged. busy=0 while in WAIT_HI; no new frame starts until rx returns high.
- Glitch: drive rx low for 4 cycles, then high -> no busy after START aborts, no done, no ferr.
- Reset mid-frame: assert reset during DATA bit 4 of 8'hF0 -> outputs go to reset values immediately. A following clean 8'h0F is received correctly with a single done pulse.

Source files
------------

// File: rtl/recepcion.sv
// UART receiver, 8N1, LSB first. Two-flop input synchronizer feeds a
// START/DATA/STOP sampling FSM that yields a byte with a done or ferr strobe.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | half-bit wait, confirm start bit (reject glitches)
// DATA    | sample 8 data bits at bit centres, LSB first
// STOP    | sample stop bit; high -> done, low -> ferr
// WAIT_HI | bad frame / line break, wait for line to return high
module recepcion #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       ferr
);

  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  // Synchronizer presets to 1 so reset looks like an idle line.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      dout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      done <= 1'b0;
      ferr <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_TC) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_TC) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_TC) begin
            cnt  <= '0;
            busy <= 1'b0;
            if (rx_s) begin
              dout  <= shreg;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recepcion.sv
// Directed bench for recepcion with 16-cycle bits: table of frames plus
// hand-written reset, glitch and mid-frame reset sequences.
module tb_recepcion;

  localparam int CPB = 16;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       ferr;

  recepcion #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk_in(clk_in),
    .reset (reset),
    .rx    (rx),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .ferr  (ferr)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int done_cnt = 0, ferr_cnt = 0, busy_cnt = 0, both_cnt = 0;
  int last_done_cyc = 0, last_ferr_cyc = 0;
  always @(negedge clk_in) begin
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (ferr) begin ferr_cnt++; last_ferr_cyc = cyc; end
    if (busy) busy_cnt++;
    if (done && ferr) both_cnt++;
  end

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Called just after a posedge; returns at the posedge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int c0);
    #1;
    c0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(posedge clk_in);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clk_in);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk_in);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_done;
    logic       exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, d0, f0, b0, prev_done;
    vecs[0] = '{8'h33, 1'b1, 20, 1'b1, 1'b0, 8'h33};
    vecs[1] = '{8'hA5, 1'b1,  0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 20, 1'b1, 1'b0, 8'h3C};
    vecs[3] = '{8'h55, 1'b0, 40, 1'b0, 1'b1, 8'h3C};
    vecs[4] = '{8'hC3, 1'b1, 20, 1'b1, 1'b0, 8'hC3};

    repeat (5) @(posedge clk_in);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    reset = 1'b1;
    repeat (100) @(posedge clk_in);
    check("idle_pulses", done_cnt + ferr_cnt, 0);
    check("idle_busy", busy_cnt, 0);

    prev_done = 0;
    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
      send_frame(vecs[v].data, vecs[v].stop, c0);
      if (vecs[v].stop == 1'b0) begin
        repeat (vecs[v].gap) @(posedge clk_in);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk_in);
      end else if (vecs[v].gap > 0) begin
        repeat (vecs[v].gap) @(posedge clk_in);
      end
      check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("v%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
      check($sformatf("v%0d_busy_len", v), busy_cnt - b0, 152);
      if (vecs[v].exp_done)
        check($sformatf("v%0d_done_time", v), last_done_cyc - c0, 155);
      else
        check($sformatf("v%0d_ferr_time", v), last_ferr_cyc - c0, 155);
      if (v == 2)
        check("b2b_spacing", last_done_cyc - prev_done, 160);
      prev_done = last_done_cyc;
    end
    check("busy_after_ferr", busy, 1'b0);

    // start-bit glitch: 4 low cycles
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    #1 rx = 1'b0;
    repeat (4) @(posedge clk_in);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk_in);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_busy_len", busy_cnt - b0, 8);
    check("glitch_busy_now", busy, 1'b0);
    check("glitch_dout", dout, 8'hC3);

    // reset in the middle of data bit 4 of 8'hF0
    d0 = done_cnt; f0 = ferr_cnt;
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk_in);
    for (int i = 0; i < 5; i++) begin
      #1 rx = (i < 4) ? 1'b0 : 1'b1;
      repeat (CPB) @(posedge clk_in);
    end
    check("pre_rst_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pulses", {30'd0, done, ferr}, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b1;
    repeat (30) @(posedge clk_in);
    check("mid_rst_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
    send_frame(8'h0F, 1'b1, c0);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk_in);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_dout", dout, 8'h0F);
    check("after_rst_time", last_done_cyc - c0, 155);
    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
